// File: rtl/cordic_div_sched.sv
// Round-robin scheduler sharing one iterative CORDIC divider among NREQ requesters.
// Optional RUN watchdog with err_o output: define CORDIC_DIV_SCHED_TIMEOUT_EN.
module cordic_div_sched #(
    parameter int NREQ      = 4,
    parameter int DWIDTH    = 16,
    parameter int ACCURANCY = 8,
    parameter int TIMEOUT   = 64,
    localparam int TW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*DWIDTH-1:0]   x_i,
    input  logic [NREQ*DWIDTH-1:0]   y_i,
    output logic [NREQ-1:0]          ack_o,
    output logic [ACCURANCY-1:0]     res_o,
    output logic [TW-1:0]            res_tag_o,
    output logic                     res_vld_o,
    output logic                     busy_o,
    output logic [DWIDTH-1:0]        div_x_o,
    output logic [DWIDTH-1:0]        div_y_o,
    output logic                     div_req_o,
    input  logic [ACCURANCY-1:0]     div_res_i,
    input  logic                     div_rdy_i
`ifdef CORDIC_DIV_SCHED_TIMEOUT_EN
    ,
    output logic                     err_o
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t                state_reg, state_next;
    logic [TW-1:0]         ptr_reg, ptr_next;
    logic [TW-1:0]         tag_reg, tag_next;
    logic [NREQ-1:0]       ack_reg, ack_next;
    logic [ACCURANCY-1:0]  res_reg, res_next;
    logic                  vld_reg, vld_next;
    logic [DWIDTH-1:0]     x_reg, x_next;
    logic [DWIDTH-1:0]     y_reg, y_next;
    logic                  dreq_reg, dreq_next;

    logic [DWIDTH-1:0]     x_arr [NREQ];
    logic [DWIDTH-1:0]     y_arr [NREQ];
    logic [TW:0]           cand_sum [NREQ];
    logic [TW-1:0]         cand_idx [NREQ];
    logic [NREQ-1:0]       cand_hit;
    logic [TW-1:0]         grant_idx;
    logic                  any_req;
    logic [TW:0]           tag_plus;
    logic [TW-1:0]         ptr_wrap;

    // Candidate gi is the requester gi positions after the pointer, modulo NREQ.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slot
            assign x_arr[gi]    = x_i[gi*DWIDTH +: DWIDTH];
            assign y_arr[gi]    = y_i[gi*DWIDTH +: DWIDTH];
            assign cand_sum[gi] = {1'b0, ptr_reg} + (TW+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (TW+1)'(NREQ))
                                ? TW'(cand_sum[gi] - (TW+1)'(NREQ))
                                : cand_sum[gi][TW-1:0];
            assign cand_hit[gi] = req_i[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                grant_idx = cand_idx[i];
            end
        end
    end

    assign any_req  = |req_i;
    assign tag_plus = {1'b0, tag_reg} + (TW+1)'(1);
    assign ptr_wrap = (tag_plus >= (TW+1)'(NREQ)) ? '0 : tag_plus[TW-1:0];

`ifdef CORDIC_DIV_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          err_reg, err_next;
`endif

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        tag_next   = tag_reg;
        ack_next   = '0;
        res_next   = res_reg;
        vld_next   = 1'b0;
        x_next     = x_reg;
        y_next     = y_reg;
        dreq_next  = dreq_reg;
`ifdef CORDIC_DIV_SCHED_TIMEOUT_EN
        cnt_next   = cnt_reg;
        err_next   = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    tag_next   = grant_idx;
                    ack_next   = NREQ'(1) << grant_idx;
                    x_next     = x_arr[grant_idx];
                    y_next     = y_arr[grant_idx];
                    state_next = LOAD;
                end
            end
            LOAD: begin
                dreq_next  = 1'b1;
                state_next = RUN;
`ifdef CORDIC_DIV_SCHED_TIMEOUT_EN
                cnt_next   = '0;
`endif
            end
            RUN: begin
                if (div_rdy_i) begin
                    res_next   = div_res_i;
                    vld_next   = 1'b1;
                    dreq_next  = 1'b0;
                    state_next = DONE;
                end
`ifdef CORDIC_DIV_SCHED_TIMEOUT_EN
                else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                    res_next   = '0;
                    vld_next   = 1'b1;
                    err_next   = 1'b1;
                    dreq_next  = 1'b0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
`endif
            end
            DONE: begin
                ptr_next   = ptr_wrap;
                state_next = GAP;
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            tag_reg   <= '0;
            ack_reg   <= '0;
            res_reg   <= '0;
            vld_reg   <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
            dreq_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            tag_reg   <= tag_next;
            ack_reg   <= ack_next;
            res_reg   <= res_next;
            vld_reg   <= vld_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            dreq_reg  <= dreq_next;
        end
    end

`ifdef CORDIC_DIV_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            err_reg <= err_next;
        end
    end

    assign err_o = err_reg;
`endif

    assign ack_o     = ack_reg;
    assign res_o     = res_reg;
    assign res_tag_o = tag_reg;
    assign res_vld_o = vld_reg;
    assign busy_o    = (state_reg != IDLE);
    assign div_x_o   = x_reg;
    assign div_y_o   = y_reg;
    assign div_req_o = dreq_reg;

endmodule

// File: tb/tb_cordic_div_sched.sv
// Randomized self-checking bench for cordic_div_sched with a behavioural divider
// and a round-robin reference model.
module tb_cordic_div_sched;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int ACC  = 8;
    localparam int TO   = 16;
    localparam int TW   = 2;
    localparam int OP_LAT = ACC + 2;   // ack cycle to result strobe with a 9-cycle divider

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_i;
    logic [NREQ*DW-1:0] x_i;
    logic [NREQ*DW-1:0] y_i;
    logic [NREQ-1:0]    ack_o;
    logic [ACC-1:0]     res_o;
    logic [TW-1:0]      res_tag_o;
    logic               res_vld_o;
    logic               busy_o;
    logic [DW-1:0]      div_x_o;
    logic [DW-1:0]      div_y_o;
    logic               div_req_o;
    logic [ACC-1:0]     div_res;
    logic               model_rdy;
    logic               force_rdy;
    logic               div_hang;
`ifdef CORDIC_DIV_SCHED_TIMEOUT_EN
    logic               err_o;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ref_ptr = 0;
    logic [DW-1:0] tb_x [NREQ];
    logic [DW-1:0] tb_y [NREQ];

    cordic_div_sched #(
        .NREQ(NREQ), .DWIDTH(DW), .ACCURANCY(ACC), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .x_i(x_i), .y_i(y_i),
        .ack_o(ack_o), .res_o(res_o), .res_tag_o(res_tag_o), .res_vld_o(res_vld_o),
        .busy_o(busy_o), .div_x_o(div_x_o), .div_y_o(div_y_o), .div_req_o(div_req_o),
        .div_res_i(div_res), .div_rdy_i(model_rdy | force_rdy)
`ifdef CORDIC_DIV_SCHED_TIMEOUT_EN
        , .err_o(err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Quotient y/x in Q1.7, saturated.
    function automatic logic [ACC-1:0] quot(input logic [DW-1:0] x, input logic [DW-1:0] y);
        int q;
        if (x == 0) return 8'hFF;
        q = (int'(y) * 128) / int'(x);
        if (q > 255) q = 255;
        return q[ACC-1:0];
    endfunction

    function automatic int exp_grant(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (p + i) % NREQ;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    // Divider model: rdy pulses ACC+1 cycles after req rises (counting the rise cycle).
    initial begin
        int dcnt;
        dcnt = 0;
        model_rdy = 1'b0;
        div_res = '0;
        forever begin
            @(negedge clk);
            model_rdy = 1'b0;
            if (!rst_n || !div_req_o) begin
                dcnt = 0;
            end else if (!div_hang) begin
                dcnt++;
                if (dcnt == ACC + 1) begin
                    model_rdy = 1'b1;
                    div_res = quot(div_x_o, div_y_o);
                    dcnt = 0;
                end
            end
        end
    end

    task automatic drive_ops();
        for (int k = 0; k < NREQ; k++) begin
            x_i[k*DW +: DW] = tb_x[k];
            y_i[k*DW +: DW] = tb_y[k];
        end
    endtask

    task automatic new_ops(input int k);
        tb_x[k] = 16'($urandom_range(16'h4000, 16'h7FFF));
        tb_y[k] = 16'($urandom_range(0, int'(tb_x[k]) - 1));
        drive_ops();
    endtask

    task automatic set_reqs(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[k] && !req_i[k]) new_ops(k);
        end
        req_i = r;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_ptr = 0;
    endtask

    // Observes one complete operation starting from an IDLE negedge.
    task automatic run_op(input bit keep, output int g, output int ack_cyc);
        int e;
        int n;
        logic [NREQ-1:0] oh;
        logic [DW-1:0] ex, ey;
        e = exp_grant(req_i, ref_ptr);
        oh = '0;
        if (e >= 0) oh[e] = 1'b1;
        n = 0;
        while (ack_o == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        g = e;
        ack_cyc = cyc;
        checks++;
        if (ack_o !== oh) begin
            errors++;
            $display("FAIL ack: got %b want %b", ack_o, oh);
        end
        if (e < 0) return;
        ex = tb_x[e];
        ey = tb_y[e];
        checks++;
        if (div_x_o !== ex || div_y_o !== ey || div_req_o !== 1'b0 || res_tag_o !== TW'(e) || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL load: x=%h y=%h req=%b tag=%0d busy=%b want x=%h y=%h req=0 tag=%0d busy=1",
                     div_x_o, div_y_o, div_req_o, res_tag_o, busy_o, ex, ey, e);
        end
        if (keep) new_ops(e);
        else req_i[e] = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (res_vld_o || n >= 40) break;
            checks++;
            if (div_req_o !== 1'b1 || div_x_o !== ex || div_y_o !== ey || ack_o !== '0) begin
                errors++;
                $display("FAIL run_hold: cyc%0d req=%b x=%h y=%h ack=%b want req=1 x=%h y=%h ack=0",
                         n, div_req_o, div_x_o, div_y_o, ack_o, ex, ey);
            end
        end
        checks++;
        if (res_vld_o !== 1'b1 || n != OP_LAT) begin
            errors++;
            $display("FAIL latency: vld=%b after %0d cycles want vld=1 after %0d", res_vld_o, n, OP_LAT);
        end
        checks++;
        if (res_o !== quot(ex, ey) || res_tag_o !== TW'(e) || div_req_o !== 1'b0) begin
            errors++;
            $display("FAIL result: res=%h tag=%0d req=%b want res=%h tag=%0d req=0",
                     res_o, res_tag_o, div_req_o, quot(ex, ey), e);
        end
`ifdef CORDIC_DIV_SCHED_TIMEOUT_EN
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_quiet: err=%b want 0", err_o);
        end
`endif
        $display("op tag=%0d x=%h y=%h res=%h", res_tag_o, ex, ey, res_o);
        @(negedge clk);
        checks++;
        if (res_vld_o !== 1'b0 || div_req_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL gap: vld=%b req=%b busy=%b want 0 0 1", res_vld_o, div_req_o, busy_o);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || ack_o !== '0) begin
            errors++;
            $display("FAIL idle: busy=%b ack=%b want 0 0", busy_o, ack_o);
        end
        ref_ptr = (e + 1) % NREQ;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (ack_o !== '0 || res_vld_o !== 1'b0 || div_req_o !== 1'b0 || res_o !== '0 ||
            res_tag_o !== '0 || div_x_o !== '0 || div_y_o !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: ack=%b vld=%b req=%b res=%h tag=%0d x=%h y=%h busy=%b want all 0",
                     ack_o, res_vld_o, div_req_o, res_o, res_tag_o, div_x_o, div_y_o, busy_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_ptr = 0;
        $display("reset done");
    endtask

    task automatic test_single();
        int g, ac;
        @(negedge clk);
        tb_x[1] = 16'h4000;
        tb_y[1] = 16'h2000;
        drive_ops();
        req_i = 4'b0010;
        run_op(1'b0, g, ac);
        checks++;
        if (g != 1 || res_o !== 8'h40) begin
            errors++;
            $display("FAIL single: grant=%0d res=%h want grant=1 res=40", g, res_o);
        end
    endtask

    task automatic test_contention();
        int order [5] = '{0, 1, 2, 3, 0};
        int g, ac, prev_ac;
        apply_reset();
        set_reqs(4'b1111);
        prev_ac = 0;
        for (int i = 0; i < 5; i++) begin
            run_op(1'b1, g, ac);
            checks++;
            if (g != order[i]) begin
                errors++;
                $display("FAIL contention_order: op%0d grant=%0d want %0d", i, g, order[i]);
            end
            if (i > 0) begin
                checks++;
                if (ac - prev_ac != OP_LAT + 3) begin
                    errors++;
                    $display("FAIL ack_spacing: %0d cycles want %0d", ac - prev_ac, OP_LAT + 3);
                end
            end
            prev_ac = ac;
        end
        req_i = '0;
    endtask

    task automatic test_wrap_fair();
        int exp_seq [4] = '{3, 0, 3, 0};
        int g, ac, prev_g;
        set_reqs(4'b1000);
        run_op(1'b0, g, ac);
        checks++;
        if (g != exp_seq[0]) begin
            errors++;
            $display("FAIL wrap: grant=%0d want %0d", g, exp_seq[0]);
        end
        prev_g = g;
        set_reqs(4'b1001);
        for (int i = 1; i < 4; i++) begin
            run_op(1'b1, g, ac);
            checks++;
            if (g != exp_seq[i] || g == prev_g) begin
                errors++;
                $display("FAIL fairness: op%0d grant=%0d prev=%0d want %0d", i, g, prev_g, exp_seq[i]);
            end
            prev_g = g;
        end
        req_i = '0;
    endtask

    task automatic test_random();
        int g, ac;
        for (int i = 0; i < 16; i++) begin
            set_reqs(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
            run_op(1'($urandom_range(0, 1)), g, ac);
        end
        req_i = '0;
    endtask

    task automatic test_spurious_rdy();
        @(negedge clk);
        force_rdy = 1'b1;
        @(negedge clk);
        force_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (res_vld_o !== 1'b0 || busy_o !== 1'b0 || div_req_o !== 1'b0) begin
            errors++;
            $display("FAIL spurious_rdy: vld=%b busy=%b req=%b want 0 0 0", res_vld_o, busy_o, div_req_o);
        end
        $display("spurious rdy in IDLE ignored check done");
    endtask

    task automatic test_reset_mid_run();
        int g, ac, n;
        set_reqs(4'b0100);
        n = 0;
        while (div_req_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (div_req_o !== 1'b0 || busy_o !== 1'b0 || res_vld_o !== 1'b0 || n >= 20) begin
            errors++;
            $display("FAIL async_reset: req=%b busy=%b vld=%b wait=%0d want 0 0 0", div_req_o, busy_o, res_vld_o, n);
        end
        req_i = 4'b0000;
        set_reqs(4'b1010);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (res_vld_o !== 1'b0 || div_req_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: vld=%b req=%b want 0 0", res_vld_o, div_req_o);
            end
        end
        rst_n = 1'b1;
        ref_ptr = 0;
        $display("reset mid-run released");
        run_op(1'b0, g, ac);
        checks++;
        if (g != 1) begin
            errors++;
            $display("FAIL post_reset_grant: grant=%0d want 1", g);
        end
        req_i = '0;
    endtask

`ifdef CORDIC_DIV_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        div_hang = 1'b1;
        set_reqs(4'b0001);
        n = 0;
        while (ack_o == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        req_i = '0;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (res_vld_o || n >= 60) break;
        end
        checks++;
        if (res_vld_o !== 1'b1 || err_o !== 1'b1 || res_o !== '0 || n != TO + 1) begin
            errors++;
            $display("FAIL timeout: vld=%b err=%b res=%h after %0d want 1 1 00 after %0d",
                     res_vld_o, err_o, res_o, n, TO + 1);
        end
        $display("timeout op err=%b res=%h", err_o, res_o);
        @(negedge clk);
        checks++;
        if (err_o !== 1'b0 || res_vld_o !== 1'b0 || div_req_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_gap: err=%b vld=%b req=%b want 0 0 0", err_o, res_vld_o, div_req_o);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: busy=%b want 0", busy_o);
        end
        div_hang = 1'b0;
        ref_ptr = 1;
    endtask
`endif

    initial begin
        req_i = '0;
        x_i = '0;
        y_i = '0;
        force_rdy = 1'b0;
        div_hang = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            tb_x[k] = 16'h4000;
            tb_y[k] = 16'h0000;
        end
        test_reset();
        test_single();
        test_contention();
        test_wrap_fair();
        test_spurious_rdy();
        test_random();
        test_reset_mid_run();
`ifdef CORDIC_DIV_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cordic_div_sched.md
Name: cordic_div_sched

Overview:
- Round-robin scheduler that shares one iterative CORDIC divider (y/x, DWIDTH in, ACCURANCY out, held-level req / one-cycle rdy pulse) among NREQ requesters.
- Captures one requester's operands, drives the divider's req until rdy, then returns the quotient with a requester tag.
- Sits between the DSP channel front-ends and the single shared divider instance.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DWIDTH, 16, operand width; must match the divider.
- ACCURANCY, 8, result width; must match the divider.
- TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  NREQ  per-requester request; level, held with operands until ack
- x_i  in  NREQ*DWIDTH  packed divisors; slice k belongs to requester k
- y_i  in  NREQ*DWIDTH  packed dividends
- ack_o  out  NREQ  one-hot, one-cycle pulse: operands of requester k captured
- res_o  out  ACCURANCY  quotient, valid with res_vld_o
- res_tag_o  out  max(1,$clog2(NREQ))  index of the owning requester
- res_vld_o  out  1  one-cycle result strobe
- busy_o  out  1  high in every state except IDLE
- div_x_o  out  DWIDTH  divisor to the divider (registered)
- div_y_o  out  DWIDTH  dividend to the divider (registered)
- div_req_o  out  1  divider request (registered)
- div_res_i  in  ACCURANCY  divider result
- div_rdy_i  in  1  divider ready pulse

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - ack_o=0, res_vld_o=0, div_req_o=0, res_o=0, res_tag_o=0, div_x_o=0, div_y_o=0, busy_o=0.
  - FSM=IDLE; round-robin pointer=0.
- FSM states: IDLE -> LOAD -> RUN -> DONE -> GAP -> IDLE.
- IDLE: if any req_i bit is high, grant the first set bit at or after the pointer (wrapping modulo NREQ). In the same clock edge:
  - register that requester's x/y slices into div_x_o/div_y_o;
  - latch its tag;
  - pulse ack_o[k];
  - go to LOAD.
- LOAD: div_req_o<=1; go to RUN. Operands are stable for at least one cycle before req rises.
- RUN: hold div_req_o=1 and the operands until div_rdy_i=1. On that cycle:
  - register div_res_i into res_o; res_vld_o<=1;
  - div_req_o<=0; go to DONE.
- DONE: res_vld_o<=0; pointer<=tag+1 (wrap modulo NREQ); go to GAP.
- GAP: one idle cycle with div_req_o=0 so the divider's internal enable clears before the next load; go to IDLE.
- Throughput: minimum 4 cycles of scheduler overhead plus the divider latency (ACCURANCY+1 cycles from req rise to rdy) per operation.
- A requester must hold req_i and its operands until it sees ack_o. It may deassert req_i the cycle after ack, or keep it high to queue another operation. A kept-high request is re-arbitrated only after every other pending requester has been served once (fairness).
- A req_i drop before ack is legal; that requester is not granted.
- div_rdy_i outside RUN is ignored.
- Simultaneous requests: exactly one ack per grant. No ack while busy_o=1.
- Reset mid-operation: everything returns to reset values immediately. The divider sees div_req_o=0. No res_vld_o is produced for the aborted operation.
- Sign handling belongs to the divider; the scheduler passes operands unmodified.

Optional Feature:
- Macro: CORDIC_DIV_SCHED_TIMEOUT_EN.
- When defined:
  - A counter runs in RUN. If div_rdy_i is not seen within TIMEOUT cycles, the scheduler forces res_o=0, pulses res_vld_o together with an extra output err_o (1 bit, reset 0, one-cycle pulse), drops div_req_o and proceeds DONE -> GAP.
  - The counter clears on entry to RUN.
- When not defined: no counter and no err_o port. RUN waits indefinitely.

Test Plan:
- Single op: NREQ=4, req_i=0010, x=16'h4000, y=16'h2000 -> ack_o=0010 once, div_req_o rises the cycle after ack, res_vld_o once with res_tag_o=1 and res_o equal to the captured div_res_i (about 0.5 in Q1.7, i.e. 8'h40).
- Contention: req_i=1111 held, pointer 0 -> grant order 0,1,2,3,0. Each ack is separated by the full op length; exactly one res_vld_o per ack with the matching tag.
- Wrap and fairness: requester 3 served, then req_i=1001 -> next grant is 0, then 3. A requester holding req high is not granted twice in a row while another is pending.
- Handshake timing: divider model pulses rdy after 9 cycles -> div_req_o high from LOAD+1 through the rdy cycle, low for DONE and GAP. div_x_o/div_y_o stable throughout RUN.
- Reset mid-RUN: assert rst_n=0 asynchronously during RUN -> div_req_o, busy_o and res_vld_o go 0 without waiting for a clock edge. After release, the first grant goes to the lowest set req_i bit.
- Timeout (macro defined, TIMEOUT=16): divider never pulses rdy -> err_o and res_vld_o pulse 16 cycles after entering RUN with res_o=0, and the scheduler returns to IDLE after GAP.
